// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Two-port round-robin arbiter in front of a single-ported instruction memory.
// The fetch port and the loader port share one access per cycle. Grants are
// combinational, responses come back exactly one cycle after the grant.
// Misaligned accesses are answered with an error and 32'hDEADBEEF without
// touching the memory.
// Optional feature: define IMEM_ARB_BOUNDS_CHECK_EN to also reject word
// addresses at or beyond DEPTH; otherwise upper address bits wrap.
module imem_port_arbiter #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic          f_err,
    output logic [31:0]   f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic          l_err,
    output logic [31:0]   l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    // ptr = 0: fetch wins a tie, ptr = 1: loader wins a tie
    logic        ptr;
    logic [31:0] sel_addr;
    logic        sel_oob;
    logic        sel_err;
    logic        unused_addr_hi;

    logic        f_rvalid_q;
    logic        f_err_q;
    logic [31:0] f_rdata_q;
    logic        l_rvalid_q;
    logic        l_err_q;
    logic [31:0] l_rdata_q;

    // Grant decision: a lone requester always wins, ties go to the ptr owner.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!reset) begin
            if (f_req && (!l_req || !ptr)) begin
                f_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end
    end

    assign sel_addr = l_gnt ? l_addr : f_addr;

`ifdef IMEM_ARB_BOUNDS_CHECK_EN
    assign sel_oob = (sel_addr[31:2] >= 30'(DEPTH));
`else
    assign sel_oob = 1'b0;
`endif

    // Bits above the word index only matter for the optional range check.
    assign unused_addr_hi = |sel_addr[31:AW+2];

    assign sel_err = (sel_addr[1:0] != 2'b00) || sel_oob;

    // Memory strobes: an erroring grant still counts as a grant but never
    // reaches the memory.
    assign mem_en    = (f_gnt || l_gnt) && !sel_err;
    assign mem_we    = mem_en && l_gnt && l_we;
    assign mem_addr  = sel_addr[AW+1:2];
    assign mem_wdata = l_wdata;

    // Priority pointer hands the next tie to the port that was not just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (f_gnt) begin
            ptr <= 1'b1;
        end else if (l_gnt) begin
            ptr <= 1'b0;
        end
    end

    // Response registers: capture the memory word or error pattern one cycle
    // after the grant; the idle port always returns zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            f_rdata_q  <= 32'h0;
            l_rvalid_q <= 1'b0;
            l_err_q    <= 1'b0;
            l_rdata_q  <= 32'h0;
        end else begin
            f_rvalid_q <= f_gnt;
            f_err_q    <= f_gnt && sel_err;
            f_rdata_q  <= !f_gnt ? 32'h0 : (sel_err ? ERR_DATA : mem_rdata);
            l_rvalid_q <= l_gnt;
            l_err_q    <= l_gnt && sel_err;
            l_rdata_q  <= !l_gnt ? 32'h0 :
                          (sel_err ? ERR_DATA : (l_we ? 32'h0 : mem_rdata));
        end
    end

    // A response still in flight when reset rises is masked so it never shows.
    always_comb begin
        f_rvalid = f_rvalid_q && !reset;
        f_err    = f_err_q && !reset;
        f_rdata  = reset ? 32'h0 : f_rdata_q;
        l_rvalid = l_rvalid_q && !reset;
        l_err    = l_err_q && !reset;
        l_rdata  = reset ? 32'h0 : l_rdata_q;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter and memory.
// Honours IMEM_ARB_BOUNDS_CHECK_EN when the design is built with it.
module tb_imem_port_arbiter;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam logic [31:0] DEAD = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req, l_req, l_we;
    logic [31:0]   f_addr, l_addr, l_wdata;
    logic          f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
    logic [31:0]   f_rdata, l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    logic [31:0]   dut_mem [DEPTH];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_idx = '0;
    logic [31:0]   bd_data = '0;

    logic [31:0]   ref_mem [DEPTH];
    bit            fetch_turn;
    logic [67:0]   exp_resp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_err(f_err), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_err(l_err), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (bd_we) dut_mem[bd_idx] <= bd_data;
        else if (mem_en && mem_we) dut_mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = dut_mem[mem_addr];

    function automatic bit addr_err(input logic [31:0] a);
`ifdef IMEM_ARB_BOUNDS_CHECK_EN
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
`else
        return (a[1:0] != 2'b00);
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
        return a;
    endfunction

    task automatic idle_inputs();
        f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
        fetch_turn = 1;
        exp_resp = '0;
    endtask

    task automatic poke(input int idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1; bd_idx = AW'(idx); bd_data = d;
        ref_mem[idx] = d;
        @(negedge clk);
        bd_we = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        f_req = 1; l_req = 1;
        #1;
        checks++;
        if ({f_gnt, l_gnt, mem_en} !== 3'b000) begin
            errors++; $display("FAIL reset_gnt got=%b want=000", {f_gnt, l_gnt, mem_en});
        end
        checks++;
        if ({f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata} !== 68'h0) begin
            errors++; $display("FAIL reset_resp got f=%b/%b/%h l=%b/%b/%h want zeros",
                               f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata);
        end
        @(negedge clk);
        reset = 0; idle_inputs();
        @(negedge clk);
        #1;
        checks++;
        if ({f_rvalid, l_rvalid} !== 2'b00) begin
            errors++; $display("FAIL reset_after_rvalid got=%b want=00", {f_rvalid, l_rvalid});
        end
    endtask

    task automatic test_fetch_only();
        poke(1, 32'h00500093);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            f_req = (i < 4); f_addr = 32'h4;
            #1;
            if (i < 4) begin
                checks++;
                if ({f_gnt, mem_en, mem_addr} !== {2'b11, 3'd1}) begin
                    errors++; $display("FAIL fetch_only_gnt i=%0d got=%b/%b/%0d want=1/1/1",
                                       i, f_gnt, mem_en, mem_addr);
                end
            end
            if (i > 0) begin
                checks++;
                if ({f_rvalid, f_err, f_rdata} !== {2'b10, 32'h00500093}) begin
                    errors++; $display("FAIL fetch_only_resp i=%0d got=%b/%b/%h want=1/0/00500093",
                                       i, f_rvalid, f_err, f_rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            f_req = (i < 4); l_req = (i < 4); f_addr = 32'h0; l_addr = 32'h4; l_we = 0;
            #1;
            if (i < 4) begin
                checks++;
                if ({f_gnt, l_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL contention_gnt i=%0d got=%b want=%b", i,
                                       {f_gnt, l_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            if (i > 0) begin
                checks++;
                if ({f_rvalid, l_rvalid} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL contention_rvalid i=%0d got=%b", i, {f_rvalid, l_rvalid});
                end
                checks++;
                if ((f_rvalid ? l_rdata : f_rdata) !== 32'h0) begin
                    errors++; $display("FAIL contention_idle_rdata i=%0d got=%h want=0", i,
                                       f_rvalid ? l_rdata : f_rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_then_fetch();
        @(negedge clk);
        l_req = 1; l_we = 1; l_addr = 32'h8; l_wdata = 32'h12345678;
        #1;
        checks++;
        if ({l_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 3'd2, 32'h12345678}) begin
            errors++; $display("FAIL write_grant got=%b/%b/%b/%0d/%h want=1/1/1/2/12345678",
                               l_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        idle_inputs(); f_req = 1; f_addr = 32'h8;
        #1;
        checks++;
        if ({f_gnt, mem_we, l_rvalid, l_err, l_rdata} !== {4'b1010, 32'h0}) begin
            errors++; $display("FAIL write_resp got gnt=%b we=%b rv=%b err=%b rd=%h",
                               f_gnt, mem_we, l_rvalid, l_err, l_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({f_rvalid, f_err, f_rdata} !== {2'b10, 32'h12345678}) begin
            errors++; $display("FAIL readback got=%b/%b/%h want=1/0/12345678", f_rvalid, f_err, f_rdata);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        f_req = 1; f_addr = 32'h2;
        #1;
        checks++;
        if ({f_gnt, mem_en} !== 2'b10) begin
            errors++; $display("FAIL misalign_fetch_en got=%b want=10", {f_gnt, mem_en});
        end
        @(negedge clk);
        idle_inputs(); l_req = 1; l_we = 1; l_addr = 32'h9; l_wdata = 32'hA5A5A5A5;
        #1;
        checks++;
        if ({f_rvalid, f_err, f_rdata} !== {2'b11, DEAD}) begin
            errors++; $display("FAIL misalign_fetch_resp got=%b/%b/%h want=1/1/deadbeef", f_rvalid, f_err, f_rdata);
        end
        checks++;
        if ({l_gnt, mem_en, mem_we} !== 3'b100) begin
            errors++; $display("FAIL misalign_write_en got=%b want=100", {l_gnt, mem_en, mem_we});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({l_rvalid, l_err, l_rdata} !== {2'b11, DEAD}) begin
            errors++; $display("FAIL misalign_write_resp got=%b/%b/%h want=1/1/deadbeef", l_rvalid, l_err, l_rdata);
        end
    endtask

    task automatic test_wrap();
        poke(0, 32'hCAFEF00D);
        @(negedge clk);
        f_req = 1; f_addr = 32'h20;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
`ifdef IMEM_ARB_BOUNDS_CHECK_EN
        if ({f_rvalid, f_err, f_rdata} !== {2'b11, DEAD}) begin
            errors++; $display("FAIL bounds_err got=%b/%b/%h want=1/1/deadbeef", f_rvalid, f_err, f_rdata);
        end
`else
        if ({f_rvalid, f_err, f_rdata} !== {2'b10, 32'hCAFEF00D}) begin
            errors++; $display("FAIL wrap_read got=%b/%b/%h want=1/0/cafef00d", f_rvalid, f_err, f_rdata);
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        f_req = 1; f_addr = 32'h4;
        @(negedge clk);
        reset = 1; idle_inputs();
        #1;
        checks++;
        if ({f_rvalid, f_err, f_rdata} !== 34'h0) begin
            errors++; $display("FAIL reset_mid_rvalid got=%b/%b/%h want=0/0/0", f_rvalid, f_err, f_rdata);
        end
        @(negedge clk);
        reset = 0; f_req = 1; l_req = 1; f_addr = 32'h0; l_addr = 32'h4;
        #1;
        checks++;
        if ({f_rvalid, l_rvalid, f_gnt, l_gnt} !== 4'b0010) begin
            errors++; $display("FAIL reset_mid_first got rv=%b gnt=%b want rv=00 gnt=10",
                               {f_rvalid, l_rvalid}, {f_gnt, l_gnt});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({f_rvalid, l_gnt} !== 2'b11) begin
            errors++; $display("FAIL reset_mid_second got=%b want=11", {f_rvalid, l_gnt});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        bit gf, gl, se, e_en, e_we;
        logic [31:0] sa;
        logic [67:0] nxt;
        do_reset();
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom());
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            f_req = 1'($urandom_range(0, 1)); f_addr = rand_addr();
            l_req = 1'($urandom_range(0, 1)); l_addr = rand_addr();
            l_we = 1'($urandom_range(0, 1)); l_wdata = $urandom();
            #1;
            if (f_req && l_req) begin gf = fetch_turn; gl = !fetch_turn; end
            else begin gf = f_req; gl = l_req; end
            sa = gl ? l_addr : f_addr;
            se = addr_err(sa);
            e_en = (gf || gl) && !se;
            e_we = e_en && gl && l_we;
            checks++;
            if ({f_gnt, l_gnt, mem_en, mem_we} !== {gf, gl, e_en, e_we}) begin
                errors++; $display("FAIL rand_ctrl i=%0d got=%b want=%b", i,
                                   {f_gnt, l_gnt, mem_en, mem_we}, {gf, gl, e_en, e_we});
            end
            if (e_en) begin
                checks++;
                if (mem_addr !== AW'(widx(sa)) || (e_we && mem_wdata !== l_wdata)) begin
                    errors++; $display("FAIL rand_mem i=%0d got addr=%0d wdata=%h want addr=%0d wdata=%h",
                                       i, mem_addr, mem_wdata, widx(sa), l_wdata);
                end
            end
            checks++;
            if ({f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata} !== exp_resp) begin
                errors++; $display("FAIL rand_resp i=%0d got=%h want=%h", i,
                                   {f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata}, exp_resp);
            end
            nxt = '0;
            if (gf) nxt[67:34] = {1'b1, se, se ? DEAD : ref_mem[widx(sa)]};
            if (gl) begin
                nxt[33:0] = {1'b1, se, se ? DEAD : (l_we ? 32'h0 : ref_mem[widx(sa)])};
                if (!se && l_we) ref_mem[widx(sa)] = l_wdata;
            end
            if (gf) fetch_turn = 0;
            if (gl) fetch_turn = 1;
            exp_resp = nxt;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        fetch_turn = 1;
        exp_resp = '0;
        test_reset();
        test_fetch_only();
        test_contention();
        test_write_then_fetch();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of 32-bit instruction words in the shared memory (power of two, 2..1024).
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH), meaning the memory word-address width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 f_req  input  1  fetch read request; held with f_addr stable until granted.
REQ-007 f_addr  input  32  fetch byte address.
REQ-008 f_gnt  output  1  fetch request accepted this cycle.
REQ-009 f_rvalid / f_err  output  1 each  fetch response valid / response is an error.
REQ-010 f_rdata  output  32  fetch read data.
REQ-011 l_req / l_we  input  1 each  loader request / write when high, read when low.
REQ-012 l_addr / l_wdata  input  32 each  loader byte address / write data.
REQ-013 l_gnt / l_rvalid / l_err  output  1 each  loader grant / response valid / error.
REQ-014 l_rdata  output  32  loader read data (0 on write responses).
REQ-015 mem_en / mem_we  output  1 each  memory access strobe / write enable.
REQ-016 mem_addr  output  AW  memory word address; mem_wdata  output  32; mem_rdata  input  32 (combinational read of mem_addr).

Function
REQ-017 One memory access per cycle; the granted request SHALL drive mem_en=1, mem_addr=addr[AW+1:2], mem_we=l_we&&l_gnt, mem_wdata=l_wdata in the grant cycle.
REQ-018 Grants SHALL be combinational from req and the 1-bit priority pointer ptr (0=fetch first, 1=loader first); at most one gnt high per cycle.
REQ-019 Single requester SHALL be granted immediately regardless of ptr.
REQ-020 Both requesting: ptr owner granted; ptr SHALL then point to the other port (round robin); a single-requester grant SHALL also set ptr to the other port.
REQ-021 No requests: mem_en=0, mem_we=0, ptr unchanged.
REQ-022 Response latency SHALL be exactly 1 cycle: rvalid of the granted port high in the cycle after gnt for one cycle, rdata registered from mem_rdata.
REQ-023 Back-to-back grants to the same port SHALL yield back-to-back rvalid pulses.
REQ-024 Misaligned address (addr[1:0]!=0) SHALL be an error: no memory access (mem_en=0), response err=1, rdata=32'hDEADBEEF.
REQ-025 Loader write response SHALL have err=0, rdata=0 unless an error condition applies.
REQ-026 Request response outputs of the non-responding port SHALL be rvalid=0, err=0, rdata=0.
REQ-027 An erroring request SHALL still consume its grant and advance ptr.

Reset
REQ-028 On reset: ptr=0, all rvalid=0, err=0, rdata=0; gnt and mem_en forced 0 while reset is high.
REQ-029 A response pending when reset asserts SHALL be discarded; no rvalid in the cycle after reset deasserts.

Configuration
REQ-030 Macro IMEM_ARB_BOUNDS_CHECK_EN defined: address with addr[31:2] >= DEPTH SHALL be an error exactly as REQ-024 (no access, err=1, 32'hDEADBEEF).
REQ-031 Macro undefined: no range check; upper address bits above AW+1 ignored (wrap-around to addr[AW+1:2]); only misalignment errors.

Verification
REQ-032 Fetch only, f_addr=0x4 each cycle, mem word1=0x00500093 -> f_gnt every cycle, f_rvalid next cycle, f_rdata=0x00500093, f_err=0.
REQ-033 f_req and l_req both high 4 cycles from reset -> grants F,L,F,L; rvalid alternates one cycle later.
REQ-034 Loader write addr 0x8 data 0x12345678, then fetch 0x8 -> mem_we=1 only in write grant cycle; fetch returns 0x12345678.
REQ-035 Fetch addr 0x2 -> mem_en=0, next cycle f_rvalid=1, f_err=1, f_rdata=0xDEADBEEF.
REQ-036 With IMEM_ARB_BOUNDS_CHECK_EN, DEPTH=8, fetch 0x20 -> error 0xDEADBEEF; without macro -> returns word 0.
REQ-037 Assert reset in the cycle after a grant -> no rvalid emitted; first request after reset granted to fetch on contention.
